// File: rtl/soc_pio_pkg.sv
// Shared register map for the SoC PIO blocks on the lightweight bridge.
// Holds word addresses, STATUS bit indices and the Avalon write payload type.
package soc_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned ST_EXPIRED = 0;
  localparam int unsigned ST_WDEN    = 1;
  localparam int unsigned ST_IRQMASK = 2;

  // Decoded Avalon write request as seen by the register file.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/soc_pio_wdog_cnt.sv
// Refresh watchdog down-counter with expiry detection.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   load          - reload count from load_val (wins over decrement)
//   load_val      - reload value
//   enable        - watchdog armed (period != 0); when low count is held at 0
//   zero_pulse    - combinational: count is about to go 1 -> 0 this cycle
//   count         - current counter value
module soc_pio_wdog_cnt #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             zero_pulse,
  output logic [CNT_W-1:0] count
);

  // A reload in the same cycle suppresses the expiry.
  assign zero_pulse = enable & ~load & (count == CNT_W'(1));

  // Counter: load > disabled-hold-at-0 > saturating decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!enable) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/soc_pio_out_wdog.sv
// Avalon-MM output PIO with refresh watchdog. When software stops writing
// DATA/OUTSET/OUTCLEAR for PERIOD cycles, out_port is forced to SAFE_VALUE
// until software clears the sticky expired flag by writing STATUS.
// Optional macro SOC_PIO_OUT_WDOG_IRQ_EN adds irq = expired & STATUS.irq_mask.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    - Avalon-MM slave write/address interface
//   readdata              - registered read data, latency 1
//   out_port              - registered PIO output
//   irq                   - (macro only) registered watchdog interrupt
module soc_pio_out_wdog
  import soc_pio_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]  SAFE_VALUE  = '0,
  parameter int unsigned       CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [WIDTH-1:0]  out_port
`ifdef SOC_PIO_OUT_WDOG_IRQ_EN
  ,
  output logic              irq
`endif
);

  bus_req_t         req;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [CNT_W-1:0] period_reg;
  logic             expired, expired_next;
  logic             refresh, period_wr, status_wr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             wdog_en;
  logic             zero_pulse;
  logic [CNT_W-1:0] wdog_count;
  logic [DATA_W-1:0] rd_next;
  logic             unused_wdata;

  assign req = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};

  // Write-data bits above the register widths are dropped by design.
  assign unused_wdata = ^req.wdata;

  assign refresh   = req.wr & ((req.addr == ADDR_DATA) | (req.addr == ADDR_OUTSET) |
                               (req.addr == ADDR_OUTCLEAR));
  assign period_wr = req.wr & (req.addr == ADDR_PERIOD);
  assign status_wr = req.wr & (req.addr == ADDR_STATUS);
  assign wdog_en   = (period_reg != '0);

  assign cnt_load     = refresh | period_wr;
  assign cnt_load_val = period_wr ? req.wdata[CNT_W-1:0] : period_reg;

  soc_pio_wdog_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .enable     (wdog_en),
    .zero_pulse (zero_pulse),
    .count      (wdog_count)
  );

  // Next data register and sticky expired flag; a STATUS write beats expiry.
  always_comb begin
    data_next    = data_reg;
    expired_next = expired;
    if (req.wr) begin
      case (req.addr)
        ADDR_DATA:     data_next = req.wdata[WIDTH-1:0];
        ADDR_OUTSET:   data_next = data_reg | req.wdata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_next = data_reg & ~req.wdata[WIDTH-1:0];
        default:       data_next = data_reg;
      endcase
    end
    if (status_wr) begin
      expired_next = 1'b0;
    end else if (zero_pulse) begin
      expired_next = 1'b1;
    end
  end

`ifdef SOC_PIO_OUT_WDOG_IRQ_EN
  logic irq_mask, irq_mask_next;

  assign irq_mask_next = status_wr ? req.wdata[ST_IRQMASK] : irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_mask <= irq_mask_next;
      irq      <= expired_next & irq_mask_next;
    end
  end
`endif

  // Read mux; registered below for a fixed latency of one cycle.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next = DATA_W'(data_reg);
      ADDR_STATUS: begin
        rd_next[ST_EXPIRED] = expired;
        rd_next[ST_WDEN]    = wdog_en;
`ifdef SOC_PIO_OUT_WDOG_IRQ_EN
        rd_next[ST_IRQMASK] = irq_mask;
`endif
      end
      ADDR_PERIOD: rd_next = DATA_W'(period_reg);
      default:     rd_next = '0;
    endcase
  end

  // Register file and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= RESET_VALUE;
      period_reg <= '0;
      expired    <= 1'b0;
      readdata   <= '0;
      out_port   <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
      if (period_wr) begin
        period_reg <= req.wdata[CNT_W-1:0];
      end
      expired  <= expired_next;
      readdata <= rd_next;
      out_port <= expired_next ? SAFE_VALUE : data_next;
    end
  end

  // A disarmed watchdog never holds a nonzero count.
  a_cnt_idle: assert property (@(posedge clk) disable iff (!reset_n)
                               (period_reg == '0) |-> (wdog_count == '0));

endmodule
